// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, branch-flush and memory-wait sequencer with timeout error and stall counter.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IDRs1_i,
    input  logic [4:0]       IDRs2_i,
    input  logic             IDUsesRs2_i,
    input  logic             IDEXMemRead_i,
    input  logic [4:0]       IDEXRd_i,
    input  logic             BranchTaken_i,
    input  logic             MemAccess_i,
    input  logic             MemReady_i,
    output logic             Hazard_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             PipeStall_o,
    output logic             Error_o,
    output logic [CNT_W-1:0] StallCnt_o
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    state_t state, next_state;
    logic [WW-1:0] wait_cnt;
    logic mem_stall, load_use, wait_last, freeze, bubble;
    assign mem_stall = MemAccess_i & ~MemReady_i;
    assign load_use  = IDEXMemRead_i & (IDEXRd_i != 5'd0) &
                       ((IDEXRd_i == IDRs1_i) | (IDUsesRs2_i & (IDEXRd_i == IDRs2_i)));
    assign wait_last = wait_cnt == WW'(TIMEOUT - 1);
    always_ff @(posedge clk_i) begin
        state <= rst_i ? RUN : next_state;
        if (rst_i || (state == RUN))
            wait_cnt <= '0;
        else if ((state == MEM_WAIT) && !MemReady_i)
            wait_cnt <= wait_cnt + WW'(1);
        if (rst_i)
            Error_o <= 1'b0;
        else if (next_state == ERROR)
            Error_o <= 1'b1;
        if (rst_i)
            StallCnt_o <= '0;
        else if (!PCWrite_o && (StallCnt_o != '1))
            StallCnt_o <= StallCnt_o + CNT_W'(1);
    end
    always_comb begin
        next_state = (state == RUN)      ? (mem_stall ? MEM_WAIT : RUN) :
                     (state == MEM_WAIT) ? (MemReady_i ? RUN : (wait_last ? ERROR : MEM_WAIT)) :
                                           ERROR;
    end
    // a freeze always outranks the load-use bubble, which outranks the branch flush
    always_comb begin
        freeze = !rst_i & (((state == RUN) & mem_stall) |
                           ((state == MEM_WAIT) & ~MemReady_i) |
                           (state == ERROR));
        bubble      = !rst_i & !freeze & load_use;
        Hazard_o    = bubble;
        PCWrite_o   = !(freeze | bubble);
        IFIDWrite_o = !(freeze | bubble);
        IFIDFlush_o = !rst_i & !freeze & !load_use & BranchTaken_i;
        PipeStall_o = freeze;
    end
endmodule
